// File: rtl/adder_arbiter.sv
// Two-requester arbiter that time-shares one external 4-bit adder and returns
// the sum with the winner's ID. Define ADDER_ARB_FIXED_PRI_EN for fixed priority.
module adder_arbiter #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   input  logic [3:0]         req0_a,
   input  logic [3:0]         req0_b,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [3:0]         req1_a,
   input  logic [3:0]         req1_b,
   output logic               req1_ready,
   output logic [3:0]         add_a,
   output logic [3:0]         add_b,
   input  logic [4:0]         add_s,
   output logic               res_valid,
   output logic [4:0]         res_sum,
   output logic               res_id,
   input  logic               res_ready,
   output logic [COUNT_W-1:0] op_count
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic       op_id;
   logic       last_id;
   logic       grant0;
   logic       grant1;

   // Requester 0 wins a tie unless it was served last (round-robin mode).
   always_comb begin
`ifdef ADDER_ARB_FIXED_PRI_EN
      grant0 = req0_valid;
`else
      grant0 = req0_valid && (!req1_valid || last_id);
`endif
      grant1 = req1_valid && !grant0;
   end

   assign req0_ready = (state == IDLE) && grant0;
   assign req1_ready = (state == IDLE) && grant1;
   assign res_valid  = (state == DONE);

   // The adder only ever sees registered operands.
   assign add_a = op_a;
   assign add_b = op_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_a     <= '0;
         op_b     <= '0;
         op_id    <= 1'b0;
         last_id  <= 1'b1;
         res_sum  <= '0;
         res_id   <= 1'b0;
         op_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_valid && req0_ready) begin
                  op_a    <= req0_a;
                  op_b    <= req0_b;
                  op_id   <= 1'b0;
                  last_id <= 1'b0;
                  state   <= CALC;
               end else if (req1_valid && req1_ready) begin
                  op_a    <= req1_a;
                  op_b    <= req1_b;
                  op_id   <= 1'b1;
                  last_id <= 1'b1;
                  state   <= CALC;
               end
            end
            CALC: begin
               res_sum <= add_s;
               res_id  <= op_id;
               state   <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  op_count <= op_count + COUNT_W'(1);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
